trb_host_bridge: RTL and testbench

- Host-side command bridge placed directly upstream of the stream trace buffer's system interfaces.
- Takes an 8-bit ready/valid byte stream from the host transport, for example a UART or JTAG byte channel.
- Decodes framed commands and drives the trace buffer's control-write and data-write channels.
- Consumes the buffer's status-read and data-read channels and returns their words to the host as byte frames.

---
 rtl/trb_host_bridge.sv | 183 ++++++++++++++++++
 tb/tb_trb_host_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trb_host_bridge.sv
// Purpose: host byte-stream command bridge for the stream trace buffer (write control/data, read status/data).
// Latency: last payload byte -> write valid 1 cycle; write/read handshake -> first response byte valid 1 cycle.
// Backpressure: one frame in flight; host bytes are stalled (RX_READY_O=0) while a write, read or response is pending.
//
// Ports:
//   CLK_I, RST_I                      clock, async active-high reset
//   RX_VALID_I/RX_READY_O/RX_DATA_I   host command bytes in
//   TX_VALID_O/TX_READY_I/TX_DATA_O   response bytes out (0xA5 ack, 0xEE error, or read word LSB first)
//   CONTROL_VALID_O/READY_I/CONTROL_O control word to buffer
//   STATUS_VALID_I/READY_O/STATUS_I   status word from buffer
//   DATA_VALID_O/DATA_READY_I/DATA_O  data word to buffer
//   DATA_VALID_I/DATA_READY_O/DATA_I  data word from buffer
module trb_host_bridge #(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 16,
  parameter int STATUS_WIDTH  = 16
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     RX_VALID_I,
  output logic                     RX_READY_O,
  input  logic [7:0]               RX_DATA_I,
  output logic                     TX_VALID_O,
  input  logic                     TX_READY_I,
  output logic [7:0]               TX_DATA_O,
  output logic                     CONTROL_VALID_O,
  input  logic                     CONTROL_READY_I,
  output logic [CONTROL_WIDTH-1:0] CONTROL_O,
  input  logic                     STATUS_VALID_I,
  output logic                     STATUS_READY_O,
  input  logic [STATUS_WIDTH-1:0]  STATUS_I,
  output logic                     DATA_VALID_O,
  input  logic                     DATA_READY_I,
  output logic [DATA_WIDTH-1:0]    DATA_O,
  input  logic                     DATA_VALID_I,
  output logic                     DATA_READY_O,
  input  logic [DATA_WIDTH-1:0]    DATA_I
);

  localparam int NB_D    = (DATA_WIDTH + 7) / 8;
  localparam int NB_C    = (CONTROL_WIDTH + 7) / 8;
  localparam int NB_S    = (STATUS_WIDTH + 7) / 8;
  localparam int NB_M0   = (NB_D > NB_C) ? NB_D : NB_C;
  localparam int NB_MAX  = (NB_M0 > NB_S) ? NB_M0 : NB_S;
  localparam int PW      = NB_MAX * 8;
  localparam int IW      = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;

  localparam logic [IW-1:0] LAST_D = IW'(NB_D - 1);
  localparam logic [IW-1:0] LAST_C = IW'(NB_C - 1);
  localparam logic [IW-1:0] LAST_S = IW'(NB_S - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_PAYLOAD,
    S_ISSUE_WRITE,
    S_WAIT_READ,
    S_TX_BYTES
  } state_t;

  state_t                   state, state_nxt;
  logic [7:0]               cmd_q;
  // One byte-lane register serves as payload assembly, write word and response buffer.
  logic [NB_MAX-1:0][7:0]   sreg;
  logic [PW-1:0]            sflat;
  logic [IW-1:0]            cnt;
  logic [IW-1:0]            tx_last;

  logic is_wc, is_rs, is_rd;
  logic rx_fire, tx_fire, wr_fire, rd_fire, rx_last;

  assign is_wc   = (cmd_q == 8'h01);
  assign is_rs   = (cmd_q == 8'h02);
  assign is_rd   = (cmd_q == 8'h04);
  assign rx_fire = RX_VALID_I & RX_READY_O;
  assign tx_fire = TX_VALID_O & TX_READY_I;
  assign wr_fire = (CONTROL_VALID_O & CONTROL_READY_I) | (DATA_VALID_O & DATA_READY_I);
  assign rd_fire = (STATUS_VALID_I & STATUS_READY_O) | (DATA_VALID_I & DATA_READY_O);
  assign rx_last = (cnt == (is_wc ? LAST_C : LAST_D));

  assign sflat     = sreg;
  assign CONTROL_O = sflat[CONTROL_WIDTH-1:0];
  assign DATA_O    = sflat[DATA_WIDTH-1:0];

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_fire) begin
          case (RX_DATA_I)
            8'h01, 8'h03: state_nxt = S_RX_PAYLOAD;
            8'h02, 8'h04: state_nxt = S_WAIT_READ;
            default:      state_nxt = S_TX_BYTES;
          endcase
        end
      end
      S_RX_PAYLOAD:  if (rx_fire && rx_last)          state_nxt = S_ISSUE_WRITE;
      S_ISSUE_WRITE: if (wr_fire)                     state_nxt = S_TX_BYTES;
      S_WAIT_READ:   if (rd_fire)                     state_nxt = S_TX_BYTES;
      S_TX_BYTES:    if (tx_fire && cnt == tx_last)   state_nxt = S_IDLE;
      default:                                        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    RX_READY_O      = 1'b0;
    TX_VALID_O      = 1'b0;
    TX_DATA_O       = 8'h00;
    CONTROL_VALID_O = 1'b0;
    DATA_VALID_O    = 1'b0;
    STATUS_READY_O  = 1'b0;
    DATA_READY_O    = 1'b0;
    case (state)
      // Gated by reset so the host sees no ready while reset is held.
      S_IDLE, S_RX_PAYLOAD: RX_READY_O = ~RST_I;
      S_ISSUE_WRITE: begin
        CONTROL_VALID_O = is_wc;
        DATA_VALID_O    = ~is_wc;
      end
      S_WAIT_READ: begin
        STATUS_READY_O = is_rs;
        DATA_READY_O   = is_rd;
      end
      S_TX_BYTES: begin
        TX_VALID_O = 1'b1;
        TX_DATA_O  = sreg[cnt];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cmd_q   <= 8'h00;
      sreg    <= '0;
      cnt     <= '0;
      tx_last <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            cmd_q   <= RX_DATA_I;
            cnt     <= '0;
            tx_last <= '0;
            case (RX_DATA_I)
              8'h01, 8'h02, 8'h03, 8'h04: sreg <= '0;
              default:                    sreg <= PW'(8'hEE);
            endcase
          end
        end
        S_RX_PAYLOAD: begin
          if (rx_fire) begin
            sreg[cnt] <= RX_DATA_I;
            cnt       <= cnt + 1'b1;
          end
        end
        S_ISSUE_WRITE: begin
          if (wr_fire) begin
            sreg    <= PW'(8'hA5);
            cnt     <= '0;
            tx_last <= '0;
          end
        end
        S_WAIT_READ: begin
          if (rd_fire) begin
            sreg    <= is_rs ? PW'(STATUS_I) : PW'(DATA_I);
            cnt     <= '0;
            tx_last <= is_rs ? LAST_S : LAST_D;
          end
        end
        S_TX_BYTES: begin
          if (tx_fire) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trb_host_bridge.sv
module tb_trb_host_bridge;

  logic        clk, rst;
  logic        RX_VALID_I, RX_READY_O;
  logic [7:0]  RX_DATA_I;
  logic        TX_VALID_O, TX_READY_I;
  logic [7:0]  TX_DATA_O;
  logic        CONTROL_VALID_O, CONTROL_READY_I;
  logic [15:0] CONTROL_O;
  logic        STATUS_VALID_I, STATUS_READY_O;
  logic [15:0] STATUS_I;
  logic        DATA_VALID_O, DATA_READY_I;
  logic [31:0] DATA_O;
  logic        DATA_VALID_I, DATA_READY_O;
  logic [31:0] DATA_I;

  trb_host_bridge #(.DATA_WIDTH(32), .CONTROL_WIDTH(16), .STATUS_WIDTH(16)) dut (
    .CLK_I(clk), .RST_I(rst),
    .RX_VALID_I(RX_VALID_I), .RX_READY_O(RX_READY_O), .RX_DATA_I(RX_DATA_I),
    .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I), .TX_DATA_O(TX_DATA_O),
    .CONTROL_VALID_O(CONTROL_VALID_O), .CONTROL_READY_I(CONTROL_READY_I), .CONTROL_O(CONTROL_O),
    .STATUS_VALID_I(STATUS_VALID_I), .STATUS_READY_O(STATUS_READY_O), .STATUS_I(STATUS_I),
    .DATA_VALID_O(DATA_VALID_O), .DATA_READY_I(DATA_READY_I), .DATA_O(DATA_O),
    .DATA_VALID_I(DATA_VALID_I), .DATA_READY_O(DATA_READY_O), .DATA_I(DATA_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] outs();
    return {2'b00, RX_READY_O, TX_VALID_O, TX_DATA_O, CONTROL_VALID_O, CONTROL_O,
            STATUS_READY_O, DATA_VALID_O, DATA_O, DATA_READY_O};
  endfunction

  // ---------------- monitors (sampled mid-cycle, transfer happens at next rising edge)
  logic [7:0]  tx_q[$];
  int          tx_cy[$];
  logic [31:0] ctrl_q[$];
  logic [31:0] dw_q[$];
  int          ctrl_cyc = 0;
  int          dvalid_cnt = 0;
  int          cvalid_cnt = 0;
  bit          hold_tx = 0, hold_c = 0, hold_d = 0;
  logic [7:0]  held_tx;
  logic [15:0] held_c;
  logic [31:0] held_d;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_tx = 0; hold_c = 0; hold_d = 0;
    end else begin
      if (hold_tx) check("tx_hold", 64'({TX_VALID_O, TX_DATA_O}), 64'({1'b1, held_tx}));
      if (hold_c)  check("ctrl_hold", 64'({CONTROL_VALID_O, CONTROL_O}), 64'({1'b1, held_c}));
      if (hold_d)  check("dwr_hold", 64'({DATA_VALID_O, DATA_O}), 64'({1'b1, held_d}));
      hold_tx = TX_VALID_O && !TX_READY_I;      held_tx = TX_DATA_O;
      hold_c  = CONTROL_VALID_O && !CONTROL_READY_I; held_c = CONTROL_O;
      hold_d  = DATA_VALID_O && !DATA_READY_I;  held_d = DATA_O;
      if (TX_VALID_O && TX_READY_I) begin tx_q.push_back(TX_DATA_O); tx_cy.push_back(cyc); end
      if (CONTROL_VALID_O) cvalid_cnt++;
      if (CONTROL_VALID_O && CONTROL_READY_I) begin ctrl_q.push_back(32'(CONTROL_O)); ctrl_cyc = cyc; end
      if (DATA_VALID_O) dvalid_cnt++;
      if (DATA_VALID_O && DATA_READY_I) dw_q.push_back(DATA_O);
    end
  end

  // ---------------- sink-side ready generators
  int   tx_mode = 0;           // 0: always ready, 1: toggle, 2: random
  bit   wr_rand = 0;
  logic c_rdy_v = 1'b1, d_rdy_v = 1'b1;

  initial begin
    TX_READY_I = 1'b0; CONTROL_READY_I = 1'b0; DATA_READY_I = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        0:       TX_READY_I = 1'b1;
        1:       TX_READY_I = ~TX_READY_I;
        default: TX_READY_I = 1'($urandom % 2);
      endcase
      CONTROL_READY_I = wr_rand ? 1'($urandom % 2) : c_rdy_v;
      DATA_READY_I    = wr_rand ? 1'($urandom % 2) : d_rdy_v;
    end
  end

  // ---------------- host and buffer drivers (called at posedge+1 phase)
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    RX_VALID_I = 1'b1; RX_DATA_I = b;
    do begin @(negedge clk); t++; end while (!RX_READY_O && t < 300);
    check("rx_accept", 64'(RX_READY_O), 64'd1);
    @(posedge clk); #1;
    RX_VALID_I = 1'b0;
  endtask

  task automatic present(input bit is_status, input logic [31:0] w, input int dly);
    int t = 0;
    repeat (dly) begin @(posedge clk); #1; end
    if (is_status) begin STATUS_VALID_I = 1'b1; STATUS_I = w[15:0]; end
    else           begin DATA_VALID_I = 1'b1;   DATA_I = w; end
    do begin @(negedge clk); t++; end
    while (!(is_status ? STATUS_READY_O : DATA_READY_O) && t < 300);
    check("rd_accept", 64'(is_status ? STATUS_READY_O : DATA_READY_O), 64'd1);
    @(posedge clk); #1;
    STATUS_VALID_I = 1'b0; DATA_VALID_I = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (tx_q.size() < n && t < 600) begin @(posedge clk); #1; t++; end
    check("tx_count", 64'(tx_q.size()), 64'(n));
  endtask

  task automatic check_tx(input string tag, input logic [7:0] exp[$]);
    logic [7:0] o;
    wait_tx(exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      o = 'x;
      if (i < tx_q.size()) o = tx_q[i];
      check($sformatf("%s_byte%0d", tag, i), 64'(o), 64'(exp[i]));
    end
  endtask

  task automatic clear_mon();
    tx_q.delete(); tx_cy.delete(); ctrl_q.delete(); dw_q.delete();
    cvalid_cnt = 0; dvalid_cnt = 0;
  endtask

  // ---------------- reference model: frame rules in plain arithmetic
  function automatic logic [31:0] pack_le(input logic [7:0] b[$], input int width);
    logic [63:0] v = 0;
    for (int i = 0; i < b.size(); i++) v = v + (64'(b[i]) << (8 * i));
    return 32'(v & ((64'd1 << width) - 1));
  endfunction

  function automatic int nb(input int width);
    return (width + 7) / 8;
  endfunction

  logic [7:0]  eq[$];
  logic [7:0]  fq[$];
  logic [31:0] w;
  int          kind, width;
  logic [7:0]  c;

  initial begin
    rst = 1'b1;
    RX_VALID_I = 0; RX_DATA_I = 0;
    STATUS_VALID_I = 0; STATUS_I = 0; DATA_VALID_I = 0; DATA_I = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", 64'(RX_READY_O), 64'd1);
    @(posedge clk); #1;

    // Reset in the middle of a data-write payload, then a normal data read.
    clear_mon();
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs", outs(), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_rx_ready", 64'(RX_READY_O), 64'd1);
    @(posedge clk); #1;
    w = $urandom;
    send_byte(8'h04);
    present(1'b0, w, 2);
    eq.delete();
    for (int i = 0; i < nb(32); i++) eq.push_back(8'(w >> (8 * i)));
    check_tx("after_reset_read", eq);
    check("no_data_write_after_reset", 64'(dvalid_cnt), 64'd0);

    // Control write with ready already high: single-cycle valid, minimum latency.
    clear_mon();
    send_byte(8'h01); send_byte(8'h34); send_byte(8'h12);
    @(negedge clk);
    check("ctrl_valid_latency", 64'({CONTROL_VALID_O, CONTROL_O}), 64'({1'b1, 16'h1234}));
    @(negedge clk);
    check("ack_latency", 64'({TX_VALID_O, TX_DATA_O, CONTROL_VALID_O}), 64'({1'b1, 8'hA5, 1'b0}));
    @(posedge clk); #1;
    eq.delete(); eq.push_back(8'hA5);
    check_tx("ctrl_ack", eq);
    check("ctrl_pulse_cycles", 64'(cvalid_cnt), 64'd1);
    check("ctrl_word", 64'(ctrl_q.size() > 0 ? ctrl_q[0] : 32'hFFFF_FFFF), 64'h1234);

    // Data write with the buffer stalling for 5 cycles.
    clear_mon();
    d_rdy_v = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h03); send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("dwr_stall_%0d", i), 64'({DATA_VALID_O, RX_READY_O, TX_VALID_O, DATA_O}),
            64'({1'b1, 1'b0, 1'b0, 32'hDEADBEEF}));
    end
    d_rdy_v = 1'b1;
    @(posedge clk); #1;
    eq.delete(); eq.push_back(8'hA5);
    check_tx("dwr_ack", eq);
    check("dwr_word", 64'(dw_q.size() > 0 ? dw_q[0] : 32'h0), 64'hDEADBEEF);

    // Data read with host toggling ready.
    clear_mon();
    tx_mode = 1;
    send_byte(8'h04);
    @(negedge clk);
    check("rd_wait_readies", 64'({DATA_READY_O, STATUS_READY_O, RX_READY_O}), 64'({1'b1, 1'b0, 1'b0}));
    @(posedge clk); #1;
    present(1'b0, 32'hCAFEF00D, 2);
    eq.delete(); eq.push_back(8'h0D); eq.push_back(8'hF0); eq.push_back(8'hFE); eq.push_back(8'hCA);
    check_tx("data_read", eq);
    tx_mode = 0;

    // Status read, then an unknown command with buffer valids asserted.
    clear_mon();
    send_byte(8'h02);
    present(1'b1, 32'h00A1, 1);
    eq.delete(); eq.push_back(8'hA1); eq.push_back(8'h00);
    check_tx("status_read", eq);
    clear_mon();
    send_byte(8'h7F);
    STATUS_VALID_I = 1'b1; DATA_VALID_I = 1'b1;
    @(negedge clk);
    check("err_no_channel", 64'({STATUS_READY_O, DATA_READY_O, CONTROL_VALID_O, DATA_VALID_O, TX_VALID_O, TX_DATA_O}),
          64'({4'b0000, 1'b1, 8'hEE}));
    @(posedge clk); #1;
    eq.delete(); eq.push_back(8'hEE);
    check_tx("error_byte", eq);
    STATUS_VALID_I = 1'b0; DATA_VALID_I = 1'b0;
    check("err_no_writes", 64'(ctrl_q.size() + dw_q.size()), 64'd0);

    // Back-to-back frames: the control write must wait for the status response.
    clear_mon();
    w = $urandom & 32'hFFFF;
    fork
      begin send_byte(8'h02); send_byte(8'h01); send_byte(8'h44); send_byte(8'h33); end
      present(1'b1, w, 4);
    join
    eq.delete(); eq.push_back(8'(w)); eq.push_back(8'(w >> 8)); eq.push_back(8'hA5);
    check_tx("stream", eq);
    check("stream_ctrl_word", 64'(ctrl_q.size() > 0 ? ctrl_q[0] : 32'h0), 64'h3344);
    check("stream_order", 64'(tx_cy.size() > 1 && ctrl_cyc > tx_cy[1]), 64'd1);

    // Randomized frames against the frame-level model.
    tx_mode = 2; wr_rand = 1;
    for (int it = 0; it < 30; it++) begin
      clear_mon();
      kind = $urandom % 5;
      fq.delete(); eq.delete();
      case (kind)
        0: begin c = 8'h01; width = 16; end
        1: begin c = 8'h02; width = 16; end
        2: begin c = 8'h03; width = 32; end
        3: begin c = 8'h04; width = 32; end
        default: begin
          c = 8'($urandom);
          if (c >= 8'h01 && c <= 8'h04) c = 8'hC0 | c;
          width = 0;
        end
      endcase
      send_byte(c);
      if (kind == 0 || kind == 2) begin
        for (int i = 0; i < nb(width); i++) fq.push_back(8'($urandom));
        foreach (fq[i]) send_byte(fq[i]);
        eq.push_back(8'hA5);
      end else if (kind == 1 || kind == 3) begin
        w = $urandom;
        if (kind == 1) w = w & 32'hFFFF;
        present(kind == 1, w, $urandom_range(0, 4));
        for (int i = 0; i < nb(width); i++) eq.push_back(8'(w >> (8 * i)));
      end else begin
        eq.push_back(8'hEE);
      end
      check_tx($sformatf("rand%0d", it), eq);
      check($sformatf("rand%0d_ctrl_n", it), 64'(ctrl_q.size()), 64'(kind == 0));
      check($sformatf("rand%0d_dwr_n", it), 64'(dw_q.size()), 64'(kind == 2));
      if (kind == 0)
        check($sformatf("rand%0d_ctrl", it), 64'(ctrl_q.size() > 0 ? ctrl_q[0] : 32'hFFFF_FFFF),
              64'(pack_le(fq, width)));
      if (kind == 2)
        check($sformatf("rand%0d_dwr", it), 64'(dw_q.size() > 0 ? dw_q[0] : ~pack_le(fq, width)),
              64'(pack_le(fq, width)));
    end
    tx_mode = 0; wr_rand = 0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
